// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, byte counts.
// Pure declarations; no timing or flow control of its own.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_e;

  function automatic logic [2:0] nbytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: nbytes = 3'd1;
      SZ_HALF: nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Datapath request/response handshake plus the big-endian data memory port.
// slave = the load/store unit, master = datapath and memory side.
interface load_store_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_address, mem_wdata, mem_write, mem_read
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_address, mem_wdata, mem_write, mem_read
  );

endinterface

// File: rtl/lsu_byte_lane.sv
// Big-endian lane extract/extend for loads and lane merge for sub-word stores.
// Purely combinational; word size passes data straight through.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rword_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [4:0]  bsh;
  logic [4:0]  hsh;
  logic [7:0]  bval;
  logic [15:0] hval;

  // Byte 0 of the word sits in the top lane, so the shift is (3 - offset) bytes.
  assign bsh  = {~addr_lo_i, 3'b000};
  assign hsh  = {~addr_lo_i[1], 4'b0000};
  assign bval = 8'(rword_i >> bsh);
  assign hval = 16'(rword_i >> hsh);

  always_comb begin
    load_o  = rword_i;
    merge_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        load_o  = {{24{bval[7] & ~unsigned_i}}, bval};
        merge_o = (rword_i & ~(32'h0000_00FF << bsh)) | ({24'b0, wdata_i[7:0]} << bsh);
      end
      SZ_HALF: begin
        load_o  = {{16{hval[15] & ~unsigned_i}}, hval};
        merge_o = (rword_i & ~(32'h0000_FFFF << hsh)) | ({16'b0, wdata_i[15:0]} << hsh);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// One-at-a-time load/store initiator; latency 1 (error), 2 (word store), READ_WAIT+1 (load), READ_WAIT+2 (sub-word store).
// req_ready only in IDLE; requests offered while busy are ignored and must be held.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int READ_WAIT = 6,
  parameter int MEM_BYTES = 1024
) (
  input  logic               clk,
  input  logic               reset,
  load_store_unit_if.slave   bus
);

  localparam int              CW        = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam logic [CW-1:0]   CNT_LAST  = CW'(READ_WAIT - 1);
  localparam logic [32:0]     MEM_LIMIT = 33'(MEM_BYTES);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          write_q, write_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rword_q, rword_d;
  logic          err_q, err_d;

  logic [32:0]   last_byte;
  logic          req_err;
  logic [31:0]   load_data;
  logic [31:0]   merge_data;

  assign last_byte = {1'b0, bus.req_addr} + 33'(nbytes(bus.req_size)) - 33'd1;
  assign req_err   = (bus.req_size == SZ_ILL)
                   || (bus.req_size == SZ_HALF && bus.req_addr[0])
                   || (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00)
                   || (last_byte >= MEM_LIMIT);

  lsu_byte_lane u_lane (
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .addr_lo_i  (addr_q[1:0]),
    .rword_i    (rword_q),
    .wdata_i    (wdata_q),
    .load_o     (load_data),
    .merge_o    (merge_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rword_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rword_q <= rword_d;
      err_q   <= err_d;
    end
  end

  // Memory strobes are decoded from state_q alone, so reset removes them asynchronously
  // and mem_wdata is always a fully merged word, never a partial one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rword_d = rword_q;
    err_d   = err_q;

    bus.req_ready   = 1'b0;
    bus.resp_valid  = 1'b0;
    bus.resp_error  = 1'b0;
    bus.resp_rdata  = '0;
    bus.mem_address = '0;
    bus.mem_wdata   = '0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          write_d = bus.req_write;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          err_d   = req_err;
          cnt_d   = '0;
          if (req_err)
            state_d = ST_DONE;
          else if (bus.req_write && bus.req_size == SZ_WORD)
            state_d = ST_WRITE;
          else
            state_d = ST_READ;
        end
      end
      ST_READ: begin
        bus.mem_read    = 1'b1;
        bus.mem_address = {addr_q[31:2], 2'b00};
        if (cnt_q == CNT_LAST) begin
          rword_d = bus.mem_rdata;
          state_d = write_q ? ST_WRITE : ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WRITE: begin
        bus.mem_write   = 1'b1;
        bus.mem_address = {addr_q[31:2], 2'b00};
        bus.mem_wdata   = merge_data;
        state_d         = ST_DONE;
      end
      ST_DONE: begin
        bus.resp_valid = 1'b1;
        bus.resp_error = err_q;
        bus.resp_rdata = (err_q || write_q) ? 32'h0 : load_data;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array reference memory predicts every cycle of the
// request/memory/response traffic; literal expectations pin the headline results.
module tb_load_store_unit;

  localparam int RW  = 6;
  localparam int MB  = 1024;

  logic clk = 1'b0;
  logic reset;
  logic mem_clear;

  load_store_unit_if bus ();

  load_store_unit #(.READ_WAIT(RW), .MEM_BYTES(MB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Word-wide memory the DUT talks to (writes on posedge, combinational read).
  logic [31:0] dmem [0:255];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 32'h0;
    end else if (bus.mem_write) begin
      dmem[bus.mem_address[9:2]] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = dmem[bus.mem_address[9:2]];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model state: byte-addressed memory and the current transaction's timeline.
  logic [7:0]  ref_mem [0:MB-1];
  bit          chk_on = 1'b0;
  bit          txn_on = 1'b0;
  int          t_acc, t_resp, t_rd0, t_rd1, t_wr;
  logic [31:0] t_waddr, t_wdata, t_rdata;
  logic        t_err;

  logic [31:0] got_rdata;
  logic        got_err;
  int          got_lat;
  int          wr_pulses;
  int          rd_cycles;

  always @(negedge clk) begin
    if (bus.mem_write) wr_pulses++;
    if (bus.mem_read)  rd_cycles++;
    if (!reset && chk_on) begin
      chk("req_ready",  {31'b0, bus.req_ready},  {31'b0, !(txn_on && cyc >= t_acc && cyc <= t_resp)});
      chk("resp_valid", {31'b0, bus.resp_valid}, {31'b0, txn_on && cyc == t_resp});
      chk("mem_read",   {31'b0, bus.mem_read},   {31'b0, txn_on && cyc >= t_rd0 && cyc < t_rd1});
      chk("mem_write",  {31'b0, bus.mem_write},  {31'b0, txn_on && cyc == t_wr});
      chk("rw_excl",    {31'b0, bus.mem_read & bus.mem_write}, 32'h0);
      if (bus.mem_read || bus.mem_write) chk("mem_address", bus.mem_address, t_waddr);
      if (bus.mem_write) chk("mem_wdata", bus.mem_wdata, t_wdata);
      if (bus.resp_valid) begin
        chk("resp_rdata", bus.resp_rdata, t_rdata);
        chk("resp_error", {31'b0, bus.resp_error}, {31'b0, t_err});
        got_rdata = bus.resp_rdata;
        got_err   = bus.resp_error;
        got_lat   = cyc - t_acc + 1;
      end
    end
  end

  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd);
    int          nb, lat, wa;
    bit          err;
    logic [31:0] v;
    @(negedge clk);
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err = (sz == 2'd3) || (a % nb != 0) || (longint'(a) + nb > MB);
    wa  = int'(a & 32'hFFFF_FFFC);
    if (err)                      lat = 1;
    else if (w && sz == 2'd2)     lat = 2;
    else if (!w)                  lat = RW + 1;
    else                          lat = RW + 2;
    t_acc   = cyc + 1;
    t_resp  = t_acc + lat - 1;
    t_rd0   = t_acc;
    t_rd1   = (!err && !(w && sz == 2'd2)) ? t_acc + RW : t_acc;
    t_wr    = (!err && w) ? ((sz == 2'd2) ? t_acc : t_acc + RW) : -1;
    t_err   = err;
    t_waddr = 32'(wa);
    t_rdata = 32'h0;
    t_wdata = 32'h0;
    if (!err && w) begin
      for (int i = 0; i < nb; i++) ref_mem[int'(a) + i] = wd[8*(nb-1-i) +: 8];
      t_wdata = {ref_mem[wa], ref_mem[wa+1], ref_mem[wa+2], ref_mem[wa+3]};
    end else if (!err) begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v = (v << 8) | {24'b0, ref_mem[int'(a) + i]};
      if (!u && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (!u && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
      t_rdata = v;
    end
    txn_on    = 1'b1;
    got_rdata = 32'hDEAD_BEEF;
    got_err   = 1'bx;
    got_lat   = -1;
    wr_pulses = 0;
    rd_cycles = 0;
    bus.req_valid    = 1'b1;
    bus.req_write    = w;
    bus.req_size     = sz;
    bus.req_unsigned = u;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (lat + 1) @(negedge clk);
  endtask

  task automatic lit(input string nm, input logic [31:0] rd, input logic er, input int lat, input int wr);
    chk({nm, "_rdata"}, got_rdata, rd);
    chk({nm, "_err"},   {31'b0, got_err}, {31'b0, er});
    chk({nm, "_lat"},   32'(got_lat), 32'(lat));
    chk({nm, "_wr"},    32'(wr_pulses), 32'(wr));
  endtask

  initial begin
    for (int i = 0; i < MB; i++) ref_mem[i] = 8'h00;
    reset = 1'b1;
    mem_clear = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, bus.req_ready}, 32'h1);
    chk("rst_rv",    {31'b0, bus.resp_valid}, 32'h0);
    chk("rst_mr",    {31'b0, bus.mem_read}, 32'h0);
    chk("rst_mw",    {31'b0, bus.mem_write}, 32'h0);
    chk("rst_addr",  bus.mem_address, 32'h0);
    chk("rst_rdata", bus.resp_rdata, 32'h0);
    reset = 1'b0;
    mem_clear = 1'b0;
    chk_on = 1'b1;

    issue(1'b1, 2'd2, 1'b0, 32'd8,  32'hAABB_CCDD); lit("wst8",  32'h0, 1'b0, 2, 1);
    issue(1'b0, 2'd2, 1'b0, 32'd8,  32'h0);         lit("wld8",  32'hAABB_CCDD, 1'b0, RW + 1, 0);
    issue(1'b0, 2'd0, 1'b0, 32'd9,  32'h0);         lit("bld9s", 32'hFFFF_FFBB, 1'b0, RW + 1, 0);
    issue(1'b0, 2'd0, 1'b1, 32'd9,  32'h0);         lit("bld9u", 32'h0000_00BB, 1'b0, RW + 1, 0);
    issue(1'b1, 2'd0, 1'b0, 32'd10, 32'h0000_0011); lit("bst10", 32'h0, 1'b0, RW + 2, 1);
    chk("bst10_reads", 32'(rd_cycles), 32'(RW));
    chk("bst10_mem",   dmem[2], 32'hAABB_11DD);
    issue(1'b0, 2'd2, 1'b0, 32'd8,  32'h0);         lit("wld8b", 32'hAABB_11DD, 1'b0, RW + 1, 0);
    issue(1'b0, 2'd1, 1'b0, 32'd10, 32'h0);         lit("hld10", 32'h0000_11DD, 1'b0, RW + 1, 0);
    issue(1'b0, 2'd1, 1'b0, 32'd8,  32'h0);         lit("hld8s", 32'hFFFF_AABB, 1'b0, RW + 1, 0);
    issue(1'b0, 2'd1, 1'b1, 32'd8,  32'h0);         lit("hld8u", 32'h0000_AABB, 1'b0, RW + 1, 0);

    issue(1'b0, 2'd2, 1'b0, 32'd6,    32'h0);       lit("e_mis",  32'h0, 1'b1, 1, 0);
    issue(1'b0, 2'd1, 1'b0, 32'd1023, 32'h0);       lit("e_h1023", 32'h0, 1'b1, 1, 0);
    issue(1'b1, 2'd2, 1'b0, 32'd1024, 32'h1234_5678); lit("e_w1024", 32'h0, 1'b1, 1, 0);
    issue(1'b0, 2'd3, 1'b0, 32'd0,    32'h0);       lit("e_sz3",  32'h0, 1'b1, 1, 0);
    chk("err_reads", 32'(rd_cycles), 32'h0);

    issue(1'b1, 2'd1, 1'b0, 32'h3FE, 32'h0000_8001); lit("hst3fe", 32'h0, 1'b0, RW + 2, 1);
    issue(1'b0, 2'd1, 1'b0, 32'h3FE, 32'h0);         lit("hld3fe", 32'hFFFF_8001, 1'b0, RW + 1, 0);

    // Abort a sub-word store with reset while it is still reading.
    chk_on = 1'b0;
    txn_on = 1'b0;
    wr_pulses = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'd9; bus.req_wdata = 32'h0000_0055;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk); @(posedge clk);
    #2 chk("abort_pre_read", {31'b0, bus.mem_read}, 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("abort_mr",    {31'b0, bus.mem_read}, 32'h0);
    chk("abort_mw",    {31'b0, bus.mem_write}, 32'h0);
    chk("abort_ready", {31'b0, bus.req_ready}, 32'h1);
    chk("abort_rv",    {31'b0, bus.resp_valid}, 32'h0);
    chk("abort_addr",  bus.mem_address, 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready_post", {31'b0, bus.req_ready}, 32'h1);
    chk("abort_wr",  32'(wr_pulses), 32'h0);
    chk("abort_mem", dmem[2], 32'hAABB_11DD);
    chk_on = 1'b1;
    issue(1'b0, 2'd2, 1'b0, 32'd8, 32'h0);          lit("wld8c", 32'hAABB_11DD, 1'b0, RW + 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-side initiator for the multicycle datapath. Accepts one load/store request at a time and drives the byte-addressed, big-endian data memory port: address, write data, write strobe and read strobe. Word stores go straight to memory. Byte and halfword stores use read-modify-write, because the memory only writes full 4-byte groups. Loads are lane-extracted and sign- or zero-extended before being returned to the datapath.

Parameters:
READ_WAIT, 6, cycles mem_address is held with mem_read=1 before mem_rdata is sampled (covers 1000 ps memory output delay at 200 ps clock); legal range >=1
MEM_BYTES, 1024, memory size in bytes; any access touching a byte >= MEM_BYTES is an error

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit idle, can accept
req_write  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
req_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified for byte/half
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data, valid with resp_valid (0 for stores/errors)
resp_error  out  1  misaligned/out-of-range/illegal size, valid with resp_valid
mem_address  out  32  word-aligned memory address
mem_wdata  out  32  write data to memory
mem_write  out  1  memory write strobe (memory writes on posedge clk)
mem_read  out  1  memory read strobe
mem_rdata  in  32  memory read data, big-endian: byte at address = bits 31:24

Behaviour:
- Reset (async): state IDLE; resp_valid, resp_error, mem_write, mem_read = 0; resp_rdata, mem_address, mem_wdata = 0. req_ready is decoded from state, so it is 1 in IDLE.
- Accept: at the posedge where req_valid && req_ready, register write, size, unsigned, addr, wdata. req_ready=1 only in IDLE.
- Error check at accept (all three give an error):
  - size==11
  - half with addr[0]!=0, or word with addr[1:0]!=0
  - addr + nbytes - 1 >= MEM_BYTES
  - On error: go to DONE with resp_error=1. No mem_read or mem_write is ever asserted.
- States: IDLE, READ, WRITE, DONE.
  - IDLE -> WRITE: word store
  - IDLE -> READ: load, or byte/half store
  - IDLE -> DONE: error
  - READ: mem_read=1, mem_address = {addr[31:2],2'b00}. A counter runs 0..READ_WAIT-1. On the final count, register mem_rdata. Next state is DONE for a load, WRITE for a sub-word store.
  - WRITE: mem_write=1 for exactly one cycle; mem_address as above. mem_wdata is either the full wdata or the read word with the target lane replaced.
  - DONE: resp_valid=1 for one cycle, then IDLE.
- Byte lanes (big-endian):
  - byte at addr[1:0]=0,1,2,3 -> bits [31:24],[23:16],[15:8],[7:0]
  - half at addr[1]=0 -> [31:16], addr[1]=1 -> [15:0]
- Load extension: bit 7 (byte) or bit 15 (half) replicated when req_unsigned=0.
- Latency, counted from the accept edge to the cycle resp_valid is high:
  - error: 1
  - word store: 2
  - load: READ_WAIT+1
  - sub-word store: READ_WAIT+2
- mem_address and mem_wdata are held stable for the whole of READ and WRITE. mem_read and mem_write are never high together.
- req_valid while busy is ignored and not queued. The request must be held until accepted.
- Reset asserted mid-operation: everything returns to IDLE immediately, and mem_write drops asynchronously. A reset coinciding with WRITE must not produce a partial merged write; the memory word keeps its old or full new value only.

Decomposition:
- Package lsu_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - state enum
  - function nbytes(size)
- Sub-module lsu_byte_lane (combinational), containing:
  - lane extract + sign/zero extend for loads
  - lane merge of wdata into the read word for sub-word stores

Test Plan:
- Word store 0xAABBCCDD @8, then word load @8 -> resp_rdata=0xAABBCCDD. Store resp at accept+2. Load resp at accept+READ_WAIT+1. Exactly one mem_write pulse, mem_address=8.
- Byte load @9: signed -> 0xFFFFFFBB; unsigned -> 0x000000BB. No mem_write.
- Byte store 0x11 @10, then word load @8 -> 0xAABB11DD. Store must show a READ phase of READ_WAIT cycles followed by one WRITE with mem_wdata=0xAABB11DD.
- Half load @10 signed -> 0x000011DD. Half load @8 signed -> 0xFFFFAABB.
- Errors, each giving resp_error=1 at accept+1 and never asserting mem_read/mem_write:
  - word @6 (misaligned)
  - half @1023
  - word @1024
  - req_size=11
- Reset pulse during READ of a sub-word store -> outputs return to reset values at once, no mem_write, req_ready=1 after release. Memory word unchanged.
